// File: rtl/switch_config_ctrl.sv
// Shadow/active select banks for the 16x16 crosspoint switch with an atomic, frame-aligned commit.
// Optional feature macro: SWCFG_BROADCAST_EN (broadcast writes to every shadow entry).
module switch_config_ctrl #(
  parameter bit          RESET_MAP      = 1'b0,
  parameter int unsigned COMMIT_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_sel,
  input  logic       wr_bcast,
  input  logic       commit_req,
  input  logic       frame_sync,
  output logic       commit_done,
  output logic       commit_timeout,
  output logic       dirty,
  input  logic [3:0] rd_addr,
  output logic [3:0] rd_sel,
  output logic [3:0] sel0,
  output logic [3:0] sel1,
  output logic [3:0] sel2,
  output logic [3:0] sel3,
  output logic [3:0] sel4,
  output logic [3:0] sel5,
  output logic [3:0] sel6,
  output logic [3:0] sel7,
  output logic [3:0] sel8,
  output logic [3:0] sel9,
  output logic [3:0] sel10,
  output logic [3:0] sel11,
  output logic [3:0] sel12,
  output logic [3:0] sel13,
  output logic [3:0] sel14,
  output logic [3:0] sel15
);

  typedef enum logic {IDLE, ARMED} state_t;

  localparam bit         TIMEOUT_EN   = (COMMIT_TIMEOUT != 0);
  localparam logic [7:0] TIMEOUT_LAST = 8'(COMMIT_TIMEOUT - 1);

  state_t     state, state_next;
  logic [3:0] shadow [16];
  logic [3:0] active [16];
  logic [7:0] cnt;
  logic       wr_fire;
  logic       commit;
  logic       forced;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // cnt holds the number of completed ARMED cycles minus one, so the forced
  // commit fires on the edge that ends the COMMIT_TIMEOUT-th ARMED cycle.
  always_comb begin
    state_next = state;
    wr_ready   = 1'b0;
    wr_fire    = 1'b0;
    commit     = 1'b0;
    forced     = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = 1'b1;
        wr_fire  = wr_valid;
        if (commit_req) state_next = ARMED;
      end
      ARMED: begin
        if (frame_sync) begin
          commit     = 1'b1;
          state_next = IDLE;
        end else if (TIMEOUT_EN && (cnt == TIMEOUT_LAST)) begin
          commit     = 1'b1;
          forced     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= 8'd0;
    else if (state == IDLE)  cnt <= 8'd0;
    else                     cnt <= cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) shadow[i] <= RESET_MAP ? 4'(i) : 4'h0;
    end else if (wr_fire) begin
`ifdef SWCFG_BROADCAST_EN
      if (wr_bcast) begin
        for (int i = 0; i < 16; i++) shadow[i] <= wr_sel;
      end else begin
        shadow[wr_addr] <= wr_sel;
      end
`else
      shadow[wr_addr] <= wr_sel;
`endif
    end
  end

`ifndef SWCFG_BROADCAST_EN
  logic bcast_unused;
  assign bcast_unused = wr_bcast;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) active[i] <= RESET_MAP ? 4'(i) : 4'h0;
    end else if (commit) begin
      for (int i = 0; i < 16; i++) active[i] <= shadow[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dirty          <= 1'b0;
      commit_done    <= 1'b0;
      commit_timeout <= 1'b0;
    end else begin
      commit_done    <= commit;
      commit_timeout <= forced;
      if (commit)       dirty <= 1'b0;
      else if (wr_fire) dirty <= 1'b1;
    end
  end

  assign rd_sel = shadow[rd_addr];

  assign sel0  = active[0];
  assign sel1  = active[1];
  assign sel2  = active[2];
  assign sel3  = active[3];
  assign sel4  = active[4];
  assign sel5  = active[5];
  assign sel6  = active[6];
  assign sel7  = active[7];
  assign sel8  = active[8];
  assign sel9  = active[9];
  assign sel10 = active[10];
  assign sel11 = active[11];
  assign sel12 = active[12];
  assign sel13 = active[13];
  assign sel14 = active[14];
  assign sel15 = active[15];

endmodule

// File: tb/tb_switch_config_ctrl.sv
// Scoreboard bench for switch_config_ctrl: two instances (identity map / timeout 4, zero map / no timeout)
// share stimulus; a reference model pushes expectations that a separate monitor pops and compares.
module tb_switch_config_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_valid = 1'b0;
  logic [3:0] wr_addr = 4'h0;
  logic [3:0] wr_sel = 4'h0;
  logic       wr_bcast = 1'b0;
  logic       commit_req = 1'b0;
  logic       frame_sync = 1'b0;
  logic [3:0] rd_addr = 4'h0;

  logic       ready [2];
  logic       done [2];
  logic       tmo [2];
  logic       dirt [2];
  logic [3:0] rd [2];
  logic [3:0] s0 [16];
  logic [3:0] s1 [16];

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [63:0] sel;
    logic [3:0]  rd;
    logic        ready;
    logic        dirty;
    logic        done;
    logic        to;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  switch_config_ctrl #(.RESET_MAP(1'b1), .COMMIT_TIMEOUT(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(ready[0]),
    .wr_addr(wr_addr), .wr_sel(wr_sel), .wr_bcast(wr_bcast),
    .commit_req(commit_req), .frame_sync(frame_sync),
    .commit_done(done[0]), .commit_timeout(tmo[0]), .dirty(dirt[0]),
    .rd_addr(rd_addr), .rd_sel(rd[0]),
    .sel0(s0[0]), .sel1(s0[1]), .sel2(s0[2]), .sel3(s0[3]),
    .sel4(s0[4]), .sel5(s0[5]), .sel6(s0[6]), .sel7(s0[7]),
    .sel8(s0[8]), .sel9(s0[9]), .sel10(s0[10]), .sel11(s0[11]),
    .sel12(s0[12]), .sel13(s0[13]), .sel14(s0[14]), .sel15(s0[15])
  );

  switch_config_ctrl #(.RESET_MAP(1'b0), .COMMIT_TIMEOUT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(ready[1]),
    .wr_addr(wr_addr), .wr_sel(wr_sel), .wr_bcast(wr_bcast),
    .commit_req(commit_req), .frame_sync(frame_sync),
    .commit_done(done[1]), .commit_timeout(tmo[1]), .dirty(dirt[1]),
    .rd_addr(rd_addr), .rd_sel(rd[1]),
    .sel0(s1[0]), .sel1(s1[1]), .sel2(s1[2]), .sel3(s1[3]),
    .sel4(s1[4]), .sel5(s1[5]), .sel6(s1[6]), .sel7(s1[7]),
    .sel8(s1[8]), .sel9(s1[9]), .sel10(s1[10]), .sel11(s1[11]),
    .sel12(s1[12]), .sel13(s1[13]), .sel14(s1[14]), .sel15(s1[15])
  );

  // Reference model: banks as arrays, a pending-commit flag and a count of ARMED cycles.
  logic [3:0] m_shadow [2][16];
  logic [3:0] m_active [2][16];
  bit         m_armed [2];
  bit         m_dirty [2];
  bit         m_done [2];
  bit         m_to [2];
  int         m_n [2];

`ifdef SWCFG_BROADCAST_EN
  localparam bit BCAST_EN = 1'b1;
`else
  localparam bit BCAST_EN = 1'b0;
`endif

  function automatic int limit_of(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  task automatic model_reset(input int k);
    for (int i = 0; i < 16; i++) begin
      m_shadow[k][i] = (k == 0) ? 4'(i) : 4'h0;
      m_active[k][i] = m_shadow[k][i];
    end
    m_armed[k] = 0; m_dirty[k] = 0; m_done[k] = 0; m_to[k] = 0; m_n[k] = 0;
  endtask

  task automatic model_edge(input int k);
    m_done[k] = 0;
    m_to[k] = 0;
    if (!m_armed[k]) begin
      if (wr_valid) begin
        if (BCAST_EN && wr_bcast) begin
          for (int i = 0; i < 16; i++) m_shadow[k][i] = wr_sel;
        end else begin
          m_shadow[k][wr_addr] = wr_sel;
        end
        m_dirty[k] = 1;
      end
      if (commit_req) begin
        m_armed[k] = 1;
        m_n[k] = 0;
      end
    end else begin
      m_n[k] = m_n[k] + 1;
      if (frame_sync || (limit_of(k) != 0 && m_n[k] == limit_of(k))) begin
        for (int i = 0; i < 16; i++) m_active[k][i] = m_shadow[k][i];
        m_dirty[k] = 0;
        m_armed[k] = 0;
        m_done[k] = 1;
        m_to[k] = !frame_sync;
      end
    end
  endtask

  function automatic exp_t model_expect(input int k);
    exp_t e;
    for (int i = 0; i < 16; i++) e.sel[i*4 +: 4] = m_active[k][i];
    e.rd = m_shadow[k][rd_addr];
    e.ready = !m_armed[k];
    e.dirty = m_dirty[k];
    e.done = m_done[k];
    e.to = m_to[k];
    return e;
  endfunction

  // One stimulus cycle, driven at a falling edge; the expectation describes the state after the next rising edge.
  task automatic applyStimulus(input bit r, input bit v, input logic [3:0] a, input logic [3:0] s,
                               input bit b, input bit cr, input bit fs, input logic [3:0] ra);
    rst_n = r; wr_valid = v; wr_addr = a; wr_sel = s; wr_bcast = b;
    commit_req = cr; frame_sync = fs; rd_addr = ra;
    for (int k = 0; k < 2; k++) begin
      if (!r) model_reset(k);
      else    model_edge(k);
    end
    q0.push_back(model_expect(0));
    q1.push_back(model_expect(1));
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int k, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL dut%0d %s got=%0h exp=%0h", k, name, got, want);
    end
  endtask

  task automatic compare_dut(input int k, input exp_t e);
    logic [63:0] got_sel;
    for (int i = 0; i < 16; i++) got_sel[i*4 +: 4] = (k == 0) ? s0[i] : s1[i];
    checkOutput("sel", k, got_sel, e.sel);
    checkOutput("rd_sel", k, 64'(rd[k]), 64'(e.rd));
    checkOutput("wr_ready", k, 64'(ready[k]), 64'(e.ready));
    checkOutput("dirty", k, 64'(dirt[k]), 64'(e.dirty));
    checkOutput("commit_done", k, 64'(done[k]), 64'(e.done));
    checkOutput("commit_timeout", k, 64'(tmo[k]), 64'(e.to));
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) compare_dut(0, q0.pop_front());
      if (q1.size() > 0) compare_dut(1, q1.pop_front());
    end
  end

  initial begin : stimulus
    #1;
    applyStimulus(0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0);
    applyStimulus(0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h7);
    applyStimulus(1, 0, 4'h0, 4'h0, 0, 0, 0, 4'hF);
    // Double write to one address, then a commit synced two cycles after the request.
    applyStimulus(1, 1, 4'h3, 4'hA, 0, 0, 0, 4'h3);
    applyStimulus(1, 1, 4'h3, 4'h5, 0, 0, 0, 4'h3);
    applyStimulus(1, 0, 4'h0, 4'h0, 0, 1, 0, 4'h3);
    applyStimulus(1, 0, 4'h0, 4'h0, 0, 0, 0, 4'h3);
    applyStimulus(1, 0, 4'h0, 4'h0, 0, 0, 1, 4'h3);
    applyStimulus(1, 0, 4'h0, 4'h0, 0, 0, 0, 4'h3);
    // A sync on the request edge must not count; a held write completes after the commit.
    applyStimulus(1, 0, 4'h0, 4'h0, 0, 1, 1, 4'h0);
    applyStimulus(1, 1, 4'h0, 4'hF, 0, 0, 0, 4'h0);
    applyStimulus(1, 1, 4'h0, 4'hF, 0, 0, 0, 4'h0);
    applyStimulus(1, 1, 4'h0, 4'hF, 0, 0, 1, 4'h0);
    applyStimulus(1, 1, 4'h0, 4'hF, 0, 0, 0, 4'h0);
    applyStimulus(1, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0);
    // No sync: instance 0 times out after four ARMED cycles, instance 1 waits.
    applyStimulus(1, 0, 4'h0, 4'h0, 0, 1, 0, 4'h0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0);
    applyStimulus(1, 0, 4'h0, 4'h0, 0, 0, 1, 4'h0);
    applyStimulus(1, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0);
    // Reset while ARMED discards the pending commit.
    applyStimulus(1, 1, 4'h9, 4'h2, 0, 0, 0, 4'h9);
    applyStimulus(1, 0, 4'h0, 4'h0, 0, 1, 0, 4'h9);
    applyStimulus(1, 0, 4'h0, 4'h0, 0, 0, 0, 4'h9);
    applyStimulus(0, 0, 4'h0, 4'h0, 0, 0, 1, 4'h9);
    applyStimulus(1, 0, 4'h0, 4'h0, 0, 0, 0, 4'h9);
    // Broadcast write, and a write issued alongside the commit request.
    applyStimulus(1, 1, 4'h5, 4'hC, 1, 0, 0, 4'h5);
    applyStimulus(1, 1, 4'h7, 4'hE, 0, 1, 0, 4'h7);
    applyStimulus(1, 0, 4'h0, 4'h0, 0, 0, 1, 4'h2);
    applyStimulus(1, 0, 4'h0, 4'h0, 0, 0, 0, 4'h7);
    for (int i = 0; i < 500; i++) begin
      applyStimulus($urandom_range(0, 199) != 0, 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 5) == 0, 4'($urandom_range(0, 15)));
    end
    @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_config_ctrl.md
# switch_config_ctrl

Configuration front-end for the 16x16 crosspoint switch. Accepts per-output select writes over a valid/ready port into a shadow bank, then copies the whole bank atomically into the active bank on a frame boundary, so all sixteen `sel` outputs change on the same edge. The sixteen `sel` outputs connect directly to the switch matrix's `sel0`..`sel15` inputs.

## Interface
- `RESET_MAP`, 0: reset contents of both banks. 0 sets every entry to 4'h0. 1 sets identity, entry i = i.
- `COMMIT_TIMEOUT`, 255: number of cycles spent in ARMED without `frame_sync` before a commit is forced. 0 disables the timeout. Range 0..255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: write can be accepted.
- `wr_addr` in 4: output index to write.
- `wr_sel` in 4: input index to route to that output.
- `wr_bcast` in 1: broadcast write (only active with the macro; see Configuration).
- `commit_req` in 1: request an atomic shadow-to-active copy.
- `frame_sync` in 1: frame-boundary strobe.
- `commit_done` out 1: one-cycle pulse when the active bank is updated.
- `commit_timeout` out 1: one-cycle pulse, coincident with `commit_done`, when the commit was forced by the timeout.
- `dirty` out 1: shadow bank differs from the active bank by at least one write since the last commit.
- `rd_addr` in 4: readback index.
- `rd_sel` out 4: combinational readback of shadow[`rd_addr`].
- `sel0`..`sel15` out 4 each: active bank entries, registered.

## Operation
- Two 16x4 register banks: shadow and active. `selN` = active[N].
- States: IDLE, ARMED.
- **IDLE**
  - `wr_ready`=1.
  - Handshake `wr_valid`&`wr_ready` at an edge writes shadow[`wr_addr`]<=`wr_sel` and sets `dirty`.
  - `commit_req`=1 moves to ARMED and clears the timeout counter.
  - `frame_sync` is ignored.
- **ARMED**
  - `wr_ready`=0; writes are backpressured.
  - `commit_req` is ignored.
  - On an edge with `frame_sync`=1: active<=shadow, `dirty`<=0, next state IDLE, `commit_done`=1 for the following cycle.
  - Otherwise the counter increments. When the counter equals `COMMIT_TIMEOUT` (nonzero), the same copy is performed and both `commit_done` and `commit_timeout` pulse.
- Commit with `dirty`=0 is still performed and still pulses `commit_done`.
- Same-cycle `wr_valid` and `commit_req` in IDLE: the write is accepted and included in the commit.
- Writes to the same address overwrite; last write wins.
- `wr_valid` may be held across ARMED; the handshake completes on the first IDLE cycle.

## Timing
- Reset values, asynchronous on `rst_n`=0:
  - state IDLE, counter 0.
  - Both banks per `RESET_MAP`; `selN` reflect it immediately.
  - `wr_ready`=1, `commit_done`=0, `commit_timeout`=0, `dirty`=0.
- Write latency: shadow is updated at the handshake edge; `rd_sel` shows the new value in the next cycle.
- Commit latency:
  - `commit_req` sampled at edge E0 puts the block in ARMED after E0.
  - `frame_sync` sampled at edge Ek (k>=1) updates all `selN` at Ek.
  - `commit_done` is high in the cycle after Ek; `wr_ready` returns to 1 in that same cycle.
- Minimum commit: `commit_req` at E0, `frame_sync` at E1, `selN` valid after E1. `frame_sync` at E0 does not count.
- Timeout: with no sync, the forced commit happens at the edge ending the `COMMIT_TIMEOUT`-th ARMED cycle.
- Reset during ARMED: the pending commit is discarded, both banks are reinitialised, no `commit_done`.

## Configuration
- `SWCFG_BROADCAST_EN`:
  - Defined: an accepted write with `wr_bcast`=1 writes `wr_sel` to all 16 shadow entries and ignores `wr_addr`.
  - Undefined: `wr_bcast` is ignored; every write is single-address.
  - All other behaviour is identical in both builds.

## Test plan
- Reset with `RESET_MAP`=1 -> `sel0`=0, `sel7`=7, `sel15`=15; `wr_ready`=1, `dirty`=0.
- Write addr 3 = 4'hA, then addr 3 = 4'h5, then `commit_req`, `frame_sync` two cycles later -> `sel3` stays unchanged until the sync edge, then 4'h5. `commit_done` pulses exactly once, `dirty` goes 1 then 0.
- In ARMED, hold `wr_valid` with addr 0 = 4'hF -> `wr_ready`=0 and `sel0` unchanged. After commit the write completes, `rd_sel`(0)=4'hF, `sel0` keeps the committed value.
- `COMMIT_TIMEOUT`=4, `commit_req`, no `frame_sync` -> forced commit after 4 ARMED cycles with `commit_done`=`commit_timeout`=1 for one cycle.
- Assert `rst_n`=0 mid-ARMED with shadow addr 9 = 4'h2 -> `sel9` at reset value, no `commit_done`, state IDLE.
- With `SWCFG_BROADCAST_EN`, broadcast 4'hC then commit -> all `selN`=4'hC. Without the macro, the same stimulus changes only `sel`[`wr_addr`].
